lvt_read_mux: RTL and testbench

- Read-side companion of the LVT-based multi-ported memory.
- Each write port owns a bank RAM. The live value table returns, per read port, the index of the write port that last wrote the address.
- This block issues reads, aligns the LVT bank index with the banked read data, and selects the live word.
- It adds write-to-read bypass and a registered output stage with a valid flag per read port.

---
 rtl/lvt_read_mux.sv | 91 +++++++++
 tb/tb_lvt_read_mux.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lvt_read_mux.sv
// Read side of an LVT multi-ported memory. It selects the live bank word for each read port
// and bypasses same-cycle writes. Each read port has two registered stages and a valid flag.
module lvt_read_mux #(
  parameter int MEMD    = 16,
  parameter int DATAW   = 32,
  parameter int nRPORTS = 2,
  parameter int nWPORTS = 2,
  parameter int BYPASS  = 1,
  localparam int ADDRW  = $clog2(MEMD),
  localparam int LVTW   = (nWPORTS > 1) ? $clog2(nWPORTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [nWPORTS-1:0]           WEnb,
  input  logic [ADDRW*nWPORTS-1:0]     WAddr,
  input  logic [DATAW*nWPORTS-1:0]     WData,
  input  logic [nRPORTS-1:0]           RReq,
  input  logic [ADDRW*nRPORTS-1:0]     RAddr,
  input  logic [LVTW*nRPORTS-1:0]      RBank,
  input  logic [DATAW*nWPORTS*nRPORTS-1:0] BankData,
  output logic [DATAW*nRPORTS-1:0]     RData,
  output logic [nRPORTS-1:0]           RVld
);

  logic [nRPORTS-1:0] v1_q, v1_d;
  logic [nRPORTS-1:0] byp1_q, byp1_d;
  logic [nRPORTS-1:0] rvld_q, rvld_d;
  logic [DATAW-1:0]   bd1_q [nRPORTS];
  logic [DATAW-1:0]   bd1_d [nRPORTS];
  logic [DATAW-1:0]   rdata_q [nRPORTS];
  logic [DATAW-1:0]   rdata_d [nRPORTS];
  logic [DATAW-1:0]   sel [nRPORTS];

  always_comb begin
    for (int p = 0; p < nRPORTS; p++) begin
      v1_d[p]   = RReq[p];
      byp1_d[p] = 1'b0;
      bd1_d[p]  = '0;
      // Higher write ports are checked later and override lower ones, the same order the LVT uses.
      if (BYPASS != 0 && RReq[p]) begin
        for (int w = 0; w < nWPORTS; w++) begin
          if (WEnb[w] && (WAddr[w*ADDRW +: ADDRW] == RAddr[p*ADDRW +: ADDRW])) begin
            byp1_d[p] = 1'b1;
            bd1_d[p]  = WData[w*DATAW +: DATAW];
          end
        end
      end

      // An out-of-range bank index falls back to bank 0.
      sel[p] = BankData[(p*nWPORTS)*DATAW +: DATAW];
      for (int w = 0; w < nWPORTS; w++) begin
        if (RBank[p*LVTW +: LVTW] == LVTW'(w))
          sel[p] = BankData[(p*nWPORTS+w)*DATAW +: DATAW];
      end
      if (byp1_q[p])
        sel[p] = bd1_q[p];

      rdata_d[p] = v1_q[p] ? sel[p] : rdata_q[p];
      rvld_d[p]  = v1_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= '0;
      byp1_q <= '0;
      rvld_q <= '0;
      for (int p = 0; p < nRPORTS; p++) begin
        bd1_q[p]   <= '0;
        rdata_q[p] <= '0;
      end
    end else begin
      v1_q   <= v1_d;
      byp1_q <= byp1_d;
      rvld_q <= rvld_d;
      for (int p = 0; p < nRPORTS; p++) begin
        bd1_q[p]   <= bd1_d[p];
        rdata_q[p] <= rdata_d[p];
      end
    end
  end

  always_comb begin
    RData = '0;
    for (int p = 0; p < nRPORTS; p++)
      RData[p*DATAW +: DATAW] = rdata_q[p];
  end

  assign RVld = rvld_q;

endmodule

// File: tb/tb_lvt_read_mux.sv
// Directed bench for lvt_read_mux. One instance bypasses same-cycle writes and one does not.
// The bench acts as the banks and LVT and checks results against a queue of expected reads.
module tb_lvt_read_mux;
  localparam int MEMD = 16, DATAW = 32, NR = 2, NW = 2, AW = 4, LW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NW-1:0]          WEnb;
  logic [AW*NW-1:0]       WAddr;
  logic [DATAW*NW-1:0]    WData;
  logic [NR-1:0]          RReq;
  logic [AW*NR-1:0]       RAddr;
  logic [LW*NR-1:0]       RBank;
  logic [DATAW*NW*NR-1:0] BankData;
  logic [DATAW*NR-1:0]    RData1, RData0;
  logic [NR-1:0]          RVld1, RVld0;

  lvt_read_mux #(.MEMD(MEMD), .DATAW(DATAW), .nRPORTS(NR), .nWPORTS(NW), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .WEnb(WEnb), .WAddr(WAddr), .WData(WData), .RReq(RReq),
    .RAddr(RAddr), .RBank(RBank), .BankData(BankData), .RData(RData1), .RVld(RVld1));

  lvt_read_mux #(.MEMD(MEMD), .DATAW(DATAW), .nRPORTS(NR), .nWPORTS(NW), .BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .WEnb(WEnb), .WAddr(WAddr), .WData(WData), .RReq(RReq),
    .RAddr(RAddr), .RBank(RBank), .BankData(BankData), .RData(RData0), .RVld(RVld0));

  typedef struct {
    int          port;
    int          due;
    logic [31:0] e1;
    logic [31:0] e0;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] bank[NW][MEMD];
  logic        lvt[MEMD];
  logic [31:0] last1[NR], last0[NR];
  int          checks = 0, errors = 0, edge_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int w, input int a, input logic [31:0] d);
    WEnb[w] = 1'b1;
    WAddr[w*AW +: AW] = AW'(a);
    WData[w*DATAW +: DATAW] = d;
  endtask

  task automatic rd(input int p, input int a);
    RReq[p] = 1'b1;
    RAddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic tick();
    logic [AW-1:0] a;
    logic [31:0]   old, byp;
    logic [NR-1:0] got;
    exp_t          e;
    if (!rst) begin
      for (int p = 0; p < NR; p++) begin
        if (RReq[p]) begin
          a = RAddr[p*AW +: AW];
          old = bank[lvt[a]][a];
          byp = old;
          for (int w = 0; w < NW; w++)
            if (WEnb[w] && WAddr[w*AW +: AW] == a) byp = WData[w*DATAW +: DATAW];
          sbq.push_back('{port: p, due: edge_cnt + 2, e1: byp, e0: old});
        end
      end
    end
    @(posedge clk);
    #1;
    edge_cnt++;
    // Banks and LVT present the pre-write contents for addresses sampled at this edge.
    for (int p = 0; p < NR; p++) begin
      a = RAddr[p*AW +: AW];
      RBank[p*LW +: LW] = lvt[a];
      for (int w = 0; w < NW; w++)
        BankData[(p*NW+w)*DATAW +: DATAW] = bank[w][a];
    end
    for (int w = 0; w < NW; w++) begin
      if (WEnb[w]) begin
        bank[w][WAddr[w*AW +: AW]] = WData[w*DATAW +: DATAW];
        lvt[WAddr[w*AW +: AW]] = w[0];
      end
    end
    if (rst) begin
      sbq.delete();
      for (int p = 0; p < NR; p++) begin
        last1[p] = '0;
        last0[p] = '0;
      end
    end
    got = '0;
    while (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
      e = sbq.pop_front();
      got[e.port] = 1'b1;
      last1[e.port] = e.e1;
      last0[e.port] = e.e0;
    end
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("rvld_byp p%0d edge%0d", p, edge_cnt), 32'(RVld1[p]), 32'(got[p]));
      chk($sformatf("rvld_nob p%0d edge%0d", p, edge_cnt), 32'(RVld0[p]), 32'(got[p]));
      chk($sformatf("rdata_byp p%0d edge%0d", p, edge_cnt), RData1[p*DATAW +: DATAW], last1[p]);
      chk($sformatf("rdata_nob p%0d edge%0d", p, edge_cnt), RData0[p*DATAW +: DATAW], last0[p]);
    end
    WEnb = '0;
    RReq = '0;
  endtask

  initial begin
    for (int a = 0; a < MEMD; a++) begin
      lvt[a] = 1'b0;
      for (int w = 0; w < NW; w++) bank[w][a] = '0;
    end
    for (int p = 0; p < NR; p++) begin
      last1[p] = '0;
      last0[p] = '0;
    end
    rst = 1'b1; WEnb = '0; WAddr = '0; WData = '0; RReq = '0; RAddr = '0;
    RBank = '0; BankData = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    wr(1, 5, 32'hDEADBEEF); tick();
    tick();
    rd(0, 5); tick();
    tick(); tick();

    wr(1, 3, 32'h99); tick();
    wr(0, 3, 32'h11); rd(1, 3); tick();
    tick(); tick();

    wr(0, 7, 32'hA); wr(1, 7, 32'hB); rd(0, 7); tick();
    rd(0, 7); tick();
    tick(); tick();

    for (int i = 0; i < 16; i++) begin
      wr(0, i, $urandom);
      wr(1, $urandom_range(15), $urandom);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      rd(0, i);
      rd(1, 15 - i);
      if ($urandom_range(1) == 1) wr(0, $urandom_range(15), $urandom);
      if ($urandom_range(1) == 1) wr(1, $urandom_range(15), $urandom);
      tick();
    end
    tick(); tick();

    rd(0, 2); rd(1, 9); tick();
    tick(); tick();
    RAddr[0 +: AW] = 4'd2; wr(0, 2, 32'h5A5A5A5A); tick();
    RAddr[AW +: AW] = 4'd9; wr(1, 9, 32'hC3C3C3C3); tick();
    tick(); tick();

    rd(0, 1); rd(1, 4); tick();
    rd(0, 6); rst = 1'b1; tick();
    rst = 1'b0; tick();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
